// File: rtl/run_controller.sv
// run_controller: sequences datapath reset release, run permission,
// single-step pausing and an instruction budget for a small core.
// Optional feature: define RUN_CTRL_CYCLE_CNT_EN to build a saturating
// counter of cycles spent in RUN. Without it CycleCount is constant zero
// and no counter register exists.
module run_controller #(
  parameter int unsigned RST_HOLD = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             CtrlRst,
  input  logic             Start,
  input  logic [CNT_W-1:0] MaxInstr,
  input  logic             InstrDone,
  input  logic             StepMode,
  input  logic             StepReq,
  output logic             CoreRst,
  output logic             Run,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Hold counter value seen on the edge that ends the reset hold.
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  state_e           state_q, state_d;
  logic [7:0]       holdCnt_q, holdCnt_d;
  logic [CNT_W-1:0] maxInstr_q, maxInstr_d;
  logic [CNT_W-1:0] instrCount_q, instrCount_d;
  logic             startAccept;
  logic             budgetHit;

  // Start is only honoured while idle or halted; in RUN/PAUSE it is ignored.
  assign startAccept = Start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  // One extra bit keeps the compare immune to wrap at an all-ones budget.
  assign budgetHit = (({1'b0, instrCount_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, maxInstr_q});

  // Next-state, hold counting, budget latch and retire counting.
  always_comb begin
    state_d      = state_q;
    holdCnt_d    = '0;
    maxInstr_d   = maxInstr_q;
    instrCount_d = instrCount_q;

    unique case (state_q)
      ST_HOLD: begin
        holdCnt_d = holdCnt_q + 8'd1;
        if (holdCnt_q == HOLD_LAST) begin
          state_d   = ST_IDLE;
          holdCnt_d = '0;
        end
      end

      ST_IDLE, ST_HALT: begin
        if (startAccept) begin
          maxInstr_d   = MaxInstr;
          instrCount_d = '0;
          state_d      = (MaxInstr == '0) ? ST_HALT : ST_RUN;
        end
      end

      ST_RUN: begin
        if (InstrDone) begin
          instrCount_d = instrCount_q + CNT_W'(1);
          if (budgetHit) begin
            state_d = ST_HALT;
          end else if (StepMode) begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        if (StepReq || !StepMode) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // Control state registers, cleared immediately by the controller reset.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      state_q      <= ST_HOLD;
      holdCnt_q    <= '0;
      maxInstr_q   <= '0;
      instrCount_q <= '0;
    end else begin
      state_q      <= state_d;
      holdCnt_q    <= holdCnt_d;
      maxInstr_q   <= maxInstr_d;
      instrCount_q <= instrCount_d;
    end
  end

  assign CoreRst    = (state_q == ST_HOLD);
  assign Run        = (state_q == ST_RUN);
  assign Halted     = (state_q == ST_HALT);
  assign State      = state_q;
  assign InstrCount = instrCount_q;

`ifdef RUN_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycleCount_q, cycleCount_d;

  // Cycles in RUN, restarted by an accepted Start and pinned at all-ones.
  always_comb begin
    cycleCount_d = cycleCount_q;
    if (startAccept) begin
      cycleCount_d = '0;
    end else if ((state_q == ST_RUN) && (cycleCount_q != '1)) begin
      cycleCount_d = cycleCount_q + CNT_W'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      cycleCount_q <= '0;
    end else begin
      cycleCount_q <= cycleCount_d;
    end
  end

  assign CycleCount = cycleCount_q;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed scenarios followed by random traffic.
// Every stimulus step pushes a predicted output snapshot into a queue and
// a separate monitor pops and compares it against the DUT.
module tb_run_controller;

  localparam int RST_HOLD = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  // Architectural state numbering exposed on the State port.
  localparam int M_HOLD  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_HALT  = 4;

  logic             CLK = 1'b0;
  logic             CtrlRst;
  logic             Start;
  logic [CNT_W-1:0] MaxInstr;
  logic             InstrDone;
  logic             StepMode;
  logic             StepReq;
  logic             CoreRst;
  logic             Run;
  logic             Halted;
  logic [CNT_W-1:0] InstrCount;
  logic [2:0]       State;
  logic [CNT_W-1:0] CycleCount;

  run_controller #(.RST_HOLD(RST_HOLD), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .CtrlRst   (CtrlRst),
    .Start     (Start),
    .MaxInstr  (MaxInstr),
    .InstrDone (InstrDone),
    .StepMode  (StepMode),
    .StepReq   (StepReq),
    .CoreRst   (CoreRst),
    .Run       (Run),
    .Halted    (Halted),
    .InstrCount(InstrCount),
    .State     (State),
    .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int state;
    int coreRst;
    int run;
    int halted;
    int instrCount;
    int cycleCount;
  } expect_t;

  expect_t expQ[$];
  event    sampleEv;
  int      checks = 0;
  int      errors = 0;
  int      stepId = 0;

  // Reference model: abstract description of controller behaviour.
  int mState;
  int mHeldEdges;
  int mBudget;
  int mRetired;
  int mCycles;

  function automatic void modelReset();
    mState     = M_HOLD;
    mHeldEdges = 0;
    mBudget    = 0;
    mRetired   = 0;
    mCycles    = 0;
  endfunction

  // Effect of one rising edge given the inputs presented before it.
  function automatic void modelEdge(bit start, int maxI, bit done, bit sm, bit sr);
    if (mState == M_HOLD) begin
      mHeldEdges++;
      if (mHeldEdges >= RST_HOLD) mState = M_IDLE;
    end else if (mState == M_IDLE || mState == M_HALT) begin
      if (start) begin
        mBudget  = maxI;
        mRetired = 0;
        mCycles  = 0;
        mState   = (maxI == 0) ? M_HALT : M_RUN;
      end
    end else if (mState == M_RUN) begin
      if (mCycles < CNT_MAX) mCycles++;
      if (done) begin
        mRetired++;
        if (mRetired == mBudget) mState = M_HALT;
        else if (sm)             mState = M_PAUSE;
      end
    end else begin
      if (sr || !sm) mState = M_RUN;
    end
  endfunction

  function automatic expect_t predict();
    expect_t e;
    e.id         = stepId;
    e.state      = mState;
    e.coreRst    = (mState == M_HOLD)  ? 1 : 0;
    e.run        = (mState == M_RUN)   ? 1 : 0;
    e.halted     = (mState == M_HALT)  ? 1 : 0;
    e.instrCount = mRetired;
`ifdef RUN_CTRL_CYCLE_CNT_EN
    e.cycleCount = mCycles;
`else
    e.cycleCount = 0;
`endif
    return e;
  endfunction

  task automatic cmpField(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    cmpField("State",      e.id, int'(State),      e.state);
    cmpField("CoreRst",    e.id, int'(CoreRst),    e.coreRst);
    cmpField("Run",        e.id, int'(Run),        e.run);
    cmpField("Halted",     e.id, int'(Halted),     e.halted);
    cmpField("InstrCount", e.id, int'(InstrCount), e.instrCount);
    cmpField("CycleCount", e.id, int'(CycleCount), e.cycleCount);
  endtask

  // Monitor: compare after each edge, or right after an asynchronous reset.
  initial begin
    forever begin
      @(posedge CLK or sampleEv);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // One clock of stimulus; the prediction covers the following rising edge.
  task automatic applyStimulus(input bit rst, input bit start, input int maxI,
                               input bit done, input bit sm, input bit sr);
    @(negedge CLK);
    CtrlRst   = rst;
    Start     = start;
    MaxInstr  = CNT_W'(maxI);
    InstrDone = done;
    StepMode  = sm;
    StepReq   = sr;
    stepId++;
    if (rst) modelReset();
    else     modelEdge(start, maxI, done, sm, sr);
    expQ.push_back(predict());
  endtask

  task automatic cyc(input bit start, input int maxI, input bit done, input bit sm, input bit sr);
    applyStimulus(1'b0, start, maxI, done, sm, sr);
  endtask

  // Assert reset between edges and check the outputs before any edge.
  task automatic applyReset();
    @(negedge CLK);
    #2;
    CtrlRst = 1'b1;
    stepId++;
    modelReset();
    expQ.push_back(predict());
    -> sampleEv;
    #2;
  endtask

  task automatic idle(input int n, input bit sm);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, sm, 1'b0);
  endtask

  initial begin
    CtrlRst   = 1'b1;
    Start     = 1'b0;
    MaxInstr  = '0;
    InstrDone = 1'b0;
    StepMode  = 1'b0;
    StepReq   = 1'b0;
    modelReset();
    #2;
    expQ.push_back(predict());
    -> sampleEv;

    // Reset held, then released: hold for RST_HOLD edges, then idle.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Budget of five with retire pulses every fourth cycle.
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(3, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Zero budget halts straight away.
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Single-step through a budget of three; ignored pulses on the way.
    cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 9, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Clearing StepMode while paused resumes running.
    cyc(1'b1, 4, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);

    // Reset mid-run after two retirements; hold sequence repeats.
    cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    applyReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);

    // All-ones budget halts at all-ones without wrapping.
    cyc(1'b1, CNT_MAX, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX + 2; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Two-instruction run, retirements three cycles apart.
    cyc(1'b1, 2, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Random traffic, including long runs that saturate the cycle counter.
    begin
      bit sm;
      sm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) sm = ~sm;
        if ($urandom_range(0, 399) == 0) begin
          applyReset();
          applyStimulus(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, CNT_MAX)),
                        1'($urandom_range(0, 1)), sm, 1'b0);
        end else begin
          cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, CNT_MAX)),
              ($urandom_range(0, 2) == 0), sm, ($urandom_range(0, 3) == 0));
        end
      end
    end

    idle(3, 1'b0);
    @(posedge CLK);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
